// File: rtl/mem_arb_pkg.sv
// Shared types for the three-way memory arbiter: FSM states, requester ids
// and the latched transaction record.
package mem_arb_pkg;

    localparam int ARB_XLEN = 32;
    localparam int ARB_AW   = 32;
    localparam int ARB_BEW  = ARB_XLEN / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_IF = 2'd0,
        OWN_DR = 2'd1,
        OWN_DW = 2'd2
    } arb_owner_e;

    typedef struct packed {
        logic [ARB_AW-1:0]   addr;
        logic [ARB_XLEN-1:0] wdata;
        logic [ARB_BEW-1:0]  be;
        logic                we;
        arb_owner_e          owner;
    } arb_txn_t;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner selection, one-hot grant {DW, DR, IF}.
// MEM_ARB_RR_EN: DR and IF alternate via the last-served pointer; DW keeps absolute priority.
module arb_pick (
    input  logic       if_req,
    input  logic       dr_req,
    input  logic       dw_req,
    input  logic       last_dr,
    output logic [2:0] gnt
);

    always_comb begin
        gnt = 3'b000;
        if (dw_req) begin
            gnt[2] = 1'b1;
        end
`ifdef MEM_ARB_RR_EN
        else if (dr_req && if_req) begin
            // Both reads contend: serve whichever did not win last time.
            if (last_dr) gnt[0] = 1'b1;
            else         gnt[1] = 1'b1;
        end
`endif
        else if (dr_req) begin
            gnt[1] = 1'b1;
        end else if (if_req) begin
            gnt[0] = 1'b1;
        end
    end

`ifndef MEM_ARB_RR_EN
    logic unused_last_dr;
    assign unused_last_dr = last_dr;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Serialises IF read, DR read and DW write onto one memory port, one transaction
// in flight. Optional MEM_ARB_RR_EN makes DR/IF alternate instead of DR > IF.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int XLEN = ARB_XLEN,
    parameter int AW   = ARB_AW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [AW-1:0]     if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [XLEN-1:0]   if_rdata,
    input  logic              if_kill,
    input  logic              dr_req,
    input  logic [AW-1:0]     dr_addr,
    output logic              dr_gnt,
    output logic              dr_rvalid,
    output logic [XLEN-1:0]   dr_rdata,
    input  logic              dw_req,
    input  logic [AW-1:0]     dw_addr,
    input  logic [XLEN-1:0]   dw_wdata,
    input  logic [XLEN/8-1:0] dw_be,
    output logic              dw_gnt,
    output logic              dw_ack,
    output logic              mem_req,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_be,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [XLEN-1:0]   mem_rdata
);

    arb_state_e state_reg, state_next;
    arb_txn_t   txn_reg, txn_next;
    logic       kill_reg, kill_next;
    logic       last_dr_reg, last_dr_next;
    logic [2:0] pick_gnt;

    arb_pick u_pick (
        .if_req  (if_req),
        .dr_req  (dr_req),
        .dw_req  (dw_req),
        .last_dr (last_dr_reg),
        .gnt     (pick_gnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            txn_reg     <= '0;
            kill_reg    <= 1'b0;
            last_dr_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            txn_reg     <= txn_next;
            kill_reg    <= kill_next;
            last_dr_reg <= last_dr_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        txn_next     = txn_reg;
        kill_next    = kill_reg;
        last_dr_next = last_dr_reg;
        if_gnt       = 1'b0;
        if_rvalid    = 1'b0;
        if_rdata     = '0;
        dr_gnt       = 1'b0;
        dr_rvalid    = 1'b0;
        dr_rdata     = '0;
        dw_gnt       = 1'b0;
        dw_ack       = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        mem_be       = '0;

        case (state_reg)
            IDLE: begin
                kill_next = 1'b0;
                if (pick_gnt[2]) begin
                    dw_gnt         = 1'b1;
                    txn_next.addr  = dw_addr;
                    txn_next.wdata = dw_wdata;
                    txn_next.be    = dw_be;
                    txn_next.we    = 1'b1;
                    txn_next.owner = OWN_DW;
                    state_next     = REQ;
                end else if (pick_gnt[1]) begin
                    dr_gnt         = 1'b1;
                    txn_next.addr  = dr_addr;
                    txn_next.wdata = '0;
                    txn_next.be    = '0;
                    txn_next.we    = 1'b0;
                    txn_next.owner = OWN_DR;
                    last_dr_next   = 1'b1;
                    state_next     = REQ;
                end else if (pick_gnt[0]) begin
                    if_gnt         = 1'b1;
                    txn_next.addr  = if_addr;
                    txn_next.wdata = '0;
                    txn_next.be    = '0;
                    txn_next.we    = 1'b0;
                    txn_next.owner = OWN_IF;
                    last_dr_next   = 1'b0;
                    // A redirect coinciding with the grant already kills this fetch.
                    kill_next      = if_kill;
                    state_next     = REQ;
                end
            end

            REQ: begin
                mem_req   = 1'b1;
                mem_we    = txn_reg.we;
                mem_addr  = txn_reg.addr;
                mem_wdata = txn_reg.wdata;
                mem_be    = txn_reg.be;
                if (txn_reg.owner == OWN_IF && if_kill) kill_next = 1'b1;
                if (mem_gnt) begin
                    if (txn_reg.we) begin
                        dw_ack     = 1'b1;
                        kill_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        state_next = RESP;
                    end
                end
            end

            RESP: begin
                if (txn_reg.owner == OWN_IF && if_kill) kill_next = 1'b1;
                if (mem_rvalid) begin
                    state_next = IDLE;
                    kill_next  = 1'b0;
                    if (txn_reg.owner == OWN_IF) begin
                        // Kill raised this very cycle must still suppress the return.
                        if_rvalid = !(kill_reg || if_kill);
                        if_rdata  = mem_rdata;
                    end else if (txn_reg.owner == OWN_DR) begin
                        dr_rvalid = 1'b1;
                        dr_rdata  = mem_rdata;
                    end
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a scoreboard queue holds expected completions
// (owner + data) in order; every negedge the completion outputs are popped against it.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req, if_gnt, if_rvalid, if_kill;
    logic [31:0] if_addr, if_rdata;
    logic        dr_req, dr_gnt, dr_rvalid;
    logic [31:0] dr_addr, dr_rdata;
    logic        dw_req, dw_gnt, dw_ack;
    logic [31:0] dw_addr, dw_wdata;
    logic [3:0]  dw_be;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    typedef struct packed {
        logic [1:0]  who;   // 0 IF, 1 DR, 2 DW
        logic [31:0] data;
    } sb_t;

    sb_t sb_q[$];
    int  vectors = 0;
    int  errors  = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_kill(if_kill),
        .dr_req(dr_req), .dr_addr(dr_addr), .dr_gnt(dr_gnt), .dr_rvalid(dr_rvalid),
        .dr_rdata(dr_rdata),
        .dw_req(dw_req), .dw_addr(dw_addr), .dw_wdata(dw_wdata), .dw_be(dw_be),
        .dw_gnt(dw_gnt), .dw_ack(dw_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] who, input logic [31:0] data);
        sb_t e;
        e.who  = who;
        e.data = data;
        sb_q.push_back(e);
    endtask

    // Completion monitor: any rvalid/ack must match the head of the scoreboard.
    task automatic mon();
        sb_t         e;
        logic [2:0]  exp_oh;
        logic [31:0] obs_data;
        if (if_rvalid || dr_rvalid || dw_ack) begin
            chk("sb_pending", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
                e        = sb_q.pop_front();
                exp_oh   = 3'b001 << e.who;
                obs_data = if_rvalid ? if_rdata : (dr_rvalid ? dr_rdata : 32'h0);
                chk("sb_who", 64'({dw_ack, dr_rvalid, if_rvalid}), 64'(exp_oh));
                if (e.who != 2'd2) chk("sb_rdata", 64'(obs_data), 64'(e.data));
                $display("txn who=%0d data=%08h", e.who, obs_data);
            end
        end
    endtask

    task automatic nedge();
        @(negedge clk);
        mon();
    endtask

    task automatic pedge();
        @(posedge clk);
        #1;
    endtask

    task automatic arb(input string tag, input logic [2:0] exp_gnt);
        nedge();
        chk(tag, 64'({dw_gnt, dr_gnt, if_gnt}), 64'(exp_gnt));
        chk("idle_no_memreq", 64'(mem_req), 64'd0);
        pedge();
    endtask

    // Entered just after the edge on which the DUT moved to REQ.
    task automatic serve(input int wait_c, input logic [31:0] exp_addr, input logic exp_we,
                         input logic [31:0] exp_wdata, input logic [3:0] exp_be,
                         input logic [31:0] rdata);
        for (int i = 0; i <= wait_c; i++) begin
            mem_gnt = (i == wait_c);
            nedge();
            chk("mem_req", 64'(mem_req), 64'd1);
            chk("mem_addr", 64'(mem_addr), 64'(exp_addr));
            chk("mem_we", 64'(mem_we), 64'(exp_we));
            if (exp_we) begin
                chk("mem_wdata", 64'(mem_wdata), 64'(exp_wdata));
                chk("mem_be", 64'(mem_be), 64'(exp_be));
            end
            pedge();
        end
        mem_gnt = 1'b0;
        if (!exp_we) begin
            mem_rvalid = 1'b1;
            mem_rdata  = rdata;
            nedge();
            chk("resp_no_memreq", 64'(mem_req), 64'd0);
            pedge();
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        if_req = 0; if_addr = 0; if_kill = 0;
        dr_req = 0; dr_addr = 0;
        dw_req = 0; dw_addr = 0; dw_wdata = 0; dw_be = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        nedge();
        chk("reset_outs", 64'(|{if_gnt, if_rvalid, if_rdata, dr_gnt, dr_rvalid, dr_rdata,
            dw_gnt, dw_ack, mem_req, mem_we, mem_addr, mem_wdata, mem_be}), 64'd0);
        pedge();
        reset_n   = 1'b1;
        mem_rdata = 32'h0;
        pedge();

        // Spurious memory handshakes while idle are ignored.
        mem_gnt = 1; mem_rvalid = 1; mem_rdata = 32'h5555_0000;
        nedge();
        chk("spurious_memreq", 64'(mem_req), 64'd0);
        pedge();
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 32'h0;

        // Single IF read, zero-wait memory.
        if_req = 1; if_addr = 32'h100;
        push(2'd0, 32'hDEAD_BEEF);
        arb("if_gnt", 3'b001);
        if_req = 0;
        serve(0, 32'h100, 1'b0, 32'h0, 4'h0, 32'hDEAD_BEEF);
        chk("t1_drain", 64'(sb_q.size()), 64'd0);

        // All three at once: DW, then DR, then IF.
        dw_req = 1; dw_addr = 32'h20; dw_wdata = 32'h55AA_55AA; dw_be = 4'hF;
        dr_req = 1; dr_addr = 32'h30;
        if_req = 1; if_addr = 32'h10;
        push(2'd2, 32'h0);
        push(2'd1, 32'hD0D0_D0D0);
        push(2'd0, 32'h1F1F_1F1F);
        arb("pri_dw", 3'b100);
        dw_req = 0;
        serve(0, 32'h20, 1'b1, 32'h55AA_55AA, 4'hF, 32'h0);
        arb("pri_dr", 3'b010);
        dr_req = 0;
        serve(0, 32'h30, 1'b0, 32'h0, 4'h0, 32'hD0D0_D0D0);
        arb("pri_if", 3'b001);
        if_req = 0;
        serve(0, 32'h10, 1'b0, 32'h0, 4'h0, 32'h1F1F_1F1F);
        chk("t2_drain", 64'(sb_q.size()), 64'd0);

        // DR read with mem_gnt delayed three cycles.
        dr_req = 1; dr_addr = 32'h40;
        push(2'd1, 32'h4040_4040);
        arb("dly_gnt", 3'b010);
        dr_req = 0;
        serve(3, 32'h40, 1'b0, 32'h0, 4'h0, 32'h4040_4040);
        chk("t3_drain", 64'(sb_q.size()), 64'd0);

        // IF read killed in RESP; the following IF read is unaffected.
        if_req = 1; if_addr = 32'h200;
        arb("kill_gnt", 3'b001);
        if_req  = 0;
        mem_gnt = 1;
        nedge();
        chk("kill_memreq", 64'(mem_req), 64'd1);
        pedge();
        mem_gnt = 0;
        if_kill = 1;
        nedge();
        pedge();
        if_kill = 0; mem_rvalid = 1; mem_rdata = 32'h1234;
        nedge();
        chk("kill_no_rvalid", 64'(if_rvalid), 64'd0);
        pedge();
        mem_rvalid = 0; mem_rdata = 32'h0;
        if_req = 1; if_addr = 32'h204;
        push(2'd0, 32'hCAFE_0204);
        arb("after_kill_gnt", 3'b001);
        if_req = 0;
        serve(0, 32'h204, 1'b0, 32'h0, 4'h0, 32'hCAFE_0204);
        chk("t4_drain", 64'(sb_q.size()), 64'd0);

        // Reset in RESP with a response arriving during reset.
        dr_req = 1; dr_addr = 32'h300;
        arb("rst_gnt", 3'b010);
        dr_req  = 0;
        mem_gnt = 1;
        nedge();
        pedge();
        mem_gnt = 0;
        reset_n = 0; mem_rvalid = 1; mem_rdata = 32'hAAAA_AAAA;
        nedge();
        chk("rst_mid_outs", 64'(|{if_gnt, if_rvalid, if_rdata, dr_gnt, dr_rvalid, dr_rdata,
            dw_gnt, dw_ack, mem_req, mem_we, mem_addr, mem_wdata, mem_be}), 64'd0);
        pedge();
        mem_rvalid = 0; mem_rdata = 32'h0;
        pedge();
        reset_n = 1;
        pedge();
        dr_req = 1; dr_addr = 32'h304;
        push(2'd1, 32'hBEEF_0304);
        arb("post_rst_gnt", 3'b010);
        dr_req = 0;
        serve(0, 32'h304, 1'b0, 32'h0, 4'h0, 32'hBEEF_0304);
        chk("t5_drain", 64'(sb_q.size()), 64'd0);

        // Fresh reset so the pointer starts at "IF last", then DR+IF held high.
        reset_n = 0;
        pedge();
        reset_n = 1;
        pedge();
        dr_req = 1; dr_addr = 32'h500;
        if_req = 1; if_addr = 32'h400;
        for (int k = 0; k < 6; k++) begin
            logic        pick_dr;
`ifdef MEM_ARB_RR_EN
            pick_dr = (k % 2 == 0);
`else
            pick_dr = 1'b1;
`endif
            push(pick_dr ? 2'd1 : 2'd0, 32'h1000 + 32'(k));
            arb("contend_gnt", pick_dr ? 3'b010 : 3'b001);
            serve(0, pick_dr ? 32'h500 : 32'h400, 1'b0, 32'h0, 4'h0, 32'h1000 + 32'(k));
        end
        dr_req = 0; if_req = 0;
        chk("t6_drain", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one downstream memory port between three core requesters: instruction fetch read (IF), data read (DR) and data write (DW).
- Sits between the core's instruction/data bus masters and the single-ported memory/interconnect.
- Serialises transactions with at most one outstanding at a time.
- Routes each read response back to the requester that issued it.

Parameters:
- XLEN, 32, data width in bits.
- AW, 32, address width in bits.

Ports:
- clk  in  1  clock
- reset_n  in  1  async active-low reset
- if_req  in  1  IF read request; held until if_gnt
- if_addr  in  AW  IF read address
- if_gnt  out  1  IF request accepted (1-cycle pulse)
- if_rvalid  out  1  IF read data valid (1-cycle pulse)
- if_rdata  out  XLEN  IF read data
- if_kill  in  1  discard the pending IF response (branch redirect)
- dr_req  in  1  data read request; held until dr_gnt
- dr_addr  in  AW  data read address
- dr_gnt  out  1  DR accepted
- dr_rvalid  out  1  DR data valid
- dr_rdata  out  XLEN  DR read data
- dw_req  in  1  data write request; held until dw_gnt
- dw_addr  in  AW  write address
- dw_wdata  in  XLEN  write data
- dw_be  in  XLEN/8  byte enables
- dw_gnt  out  1  DW accepted
- dw_ack  out  1  write completed downstream
- mem_req  out  1  downstream request
- mem_we  out  1  downstream write enable
- mem_addr  out  AW  downstream address
- mem_wdata  out  XLEN  downstream write data
- mem_be  out  XLEN/8  downstream byte enables
- mem_gnt  in  1  downstream accepted request
- mem_rvalid  in  1  downstream read data valid
- mem_rdata  in  XLEN  downstream read data

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous, active-low.
- Reset state: FSM IDLE; all outputs 0; latched addr/wdata/be/owner 0; kill flag 0.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Select a winner among asserted requests. Fixed priority DW > DR > IF.
  - Pulse that requester's *_gnt for one cycle (combinational from req in IDLE).
  - Latch addr, wdata, be, we and owner.
  - Next state REQ. No request: stay in IDLE.
- REQ:
  - mem_req=1 with the latched fields; the fields are stable until mem_gnt.
  - On mem_gnt with a write: dw_ack=1 that cycle; next state IDLE.
  - On mem_gnt with a read: next state RESP.
- RESP:
  - mem_req=0. Wait for mem_rvalid.
  - On mem_rvalid: owner's *_rvalid=1 and *_rdata=mem_rdata in the same cycle (combinational pass-through); next state IDLE.
  - Non-owner rvalid outputs stay 0. rdata outputs may carry mem_rdata, but are qualified only by rvalid.
- Latency with a zero-wait memory:
  - Read: gnt in cycle 0, mem_gnt in cycle 1, rvalid in cycle 2.
  - Write: ack in cycle 1.
  - Next grant possible in the cycle after completion.
- if_kill:
  - Asserted while owner=IF in REQ or RESP: set the kill flag.
  - The transaction still completes downstream; if_rvalid is suppressed and the flag clears on return to IDLE.
  - if_kill in IDLE, or with another owner, is ignored.
  - if_kill in the same cycle as if_gnt applies to that transaction.
- Spurious inputs: mem_rvalid in IDLE or REQ is ignored; mem_gnt outside REQ is ignored.
- Requests that drop before their gnt are simply not served. No request is ever lost once gnt has pulsed.
- Reset mid-transaction: return to IDLE immediately, and drop any response. The downstream side must be reset concurrently.

Optional Feature:
- Macro: MEM_ARB_RR_EN.
- Defined: DW keeps absolute priority. DR and IF alternate via a 1-bit last-served pointer: when both request, the one not served last wins. The pointer updates on each DR/IF grant and resets to "IF last".
- Undefined: fixed priority DW > DR > IF, and IF can starve under continuous DR traffic.

Decomposition:
- Package mem_arb_pkg holds:
  - typedef enum arb_state_e {IDLE, REQ, RESP}
  - typedef enum arb_owner_e {OWN_IF, OWN_DR, OWN_DW}
  - packed struct arb_txn_t {addr, wdata, be, we, owner}
- Sub-module arb_pick: combinational winner selection from the three req bits plus the RR pointer; outputs a one-hot grant. It contains the MEM_ARB_RR_EN logic.

Test Plan:
- Single IF read from 0x100, mem_gnt immediate, rdata 0xDEADBEEF one cycle later -> if_gnt in c0, mem_req/addr 0x100 in c1, if_rvalid with 0xDEADBEEF in c2, dr_rvalid stays 0.
- if_req, dr_req and dw_req asserted together (DW addr 0x20, wdata 0x55AA55AA, be 0xF) -> order DW, DR, IF. dw_ack precedes dr_rvalid, which precedes if_rvalid. mem_we=1 only for DW.
- mem_gnt delayed 3 cycles on a DR read from 0x40 -> mem_req and mem_addr=0x40 held stable for 4 cycles; dr_rvalid only after mem_rvalid.
- IF read granted, if_kill pulsed in RESP, mem_rvalid with 0x1234 -> if_rvalid stays 0. FSM returns to IDLE and the next IF read returns data normally.
- reset_n dropped in RESP, mem_rvalid arriving during reset -> all outputs 0 and no rvalid. After release, a new DR read completes normally.
- With MEM_ARB_RR_EN: dr_req and if_req held high for 6 transactions -> grants alternate DR, IF, DR, IF, DR, IF (first DR, since the reset pointer is "IF last"). Without the macro: six DR grants in a row.
